// File: rtl/key_mode_pkg.sv
// ============================================================================
// key_mode_pkg : shared LED mode encodings, key FSM state type, counter sizing
// Revision     : 1.0
// ============================================================================
`default_nettype none

package key_mode_pkg;

  // One-hot LED modes, shared with the flow_led pattern engine
  localparam logic [3:0] MODE_1 = 4'b0001;
  localparam logic [3:0] MODE_2 = 4'b0010;
  localparam logic [3:0] MODE_3 = 4'b0100;
  localparam logic [3:0] MODE_4 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_e;

  // Width needed to hold the values 0..n inclusive (so counters can saturate at n)
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_sync.sv
// ============================================================================
// key_sync : two-flop synchroniser for the raw key pin, output is 1 = pressed
// Revision : 1.0
// ============================================================================
`default_nettype none

module key_sync #(
  parameter int KEY_ACTIVE_LOW = 1
) (
  input  logic sys_clk_i,
  input  logic sys_rst_i,
  input  logic key_i,
  output logic pressed_o
);

  localparam logic RELEASED = (KEY_ACTIVE_LOW != 0);

  logic meta_q;
  logic sync_q;

  // Reset to the released pin level so no phantom press follows reset
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      meta_q <= RELEASED;
      sync_q <= RELEASED;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
    end
  end

  assign pressed_o = sync_q ^ RELEASED;

endmodule

`default_nettype wire

// File: rtl/key_mode_ctrl.sv
// ============================================================================
// key_mode_ctrl : key debounce, press/release pulses and one-hot LED mode reg.
// Optional long-press-to-MODE_1 enabled by defining KEY_MODE_LONG_PRESS_EN.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module key_mode_ctrl
  import key_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 2_000_000,
  parameter int unsigned LONG_PRESS_CYCLES = 200_000_000,
  parameter int          KEY_ACTIVE_LOW    = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       key_press,
  output logic       key_release,
  output logic [3:0] mode,
  output logic       mode_change,
  output logic       long_press
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             k;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_level_q, key_level_d;
  logic             key_press_q, key_press_d;
  logic             key_release_q, key_release_d;
  logic [3:0]       mode_q, mode_d;
  logic             mode_change_q, mode_change_d;
  logic             long_hit;

  key_sync #(
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_key_sync (
    .sys_clk_i (sys_clk),
    .sys_rst_i (sys_rst),
    .key_i     (key_in),
    .pressed_o (k)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      key_level_q   <= 1'b0;
      key_press_q   <= 1'b0;
      key_release_q <= 1'b0;
      mode_q        <= MODE_1;
      mode_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
      mode_q        <= mode_d;
      mode_change_q <= mode_change_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (k) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!k) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!k) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (k) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so pulses appear the cycle after the deciding edge
  always_comb begin
    key_level_d   = key_level_q;
    key_press_d   = 1'b0;
    key_release_d = 1'b0;
    mode_d        = mode_q;
    mode_change_d = 1'b0;
    if (state_q == PRESS_DB && k && cnt_q == DB_LAST) begin
      key_level_d   = 1'b1;
      key_press_d   = 1'b1;
      mode_d        = {mode_q[2:0], mode_q[3]};
      mode_change_d = 1'b1;
    end
    if (state_q == RELEASE_DB && !k && cnt_q == DB_LAST) begin
      key_level_d   = 1'b0;
      key_release_d = 1'b1;
    end
    if (long_hit) begin
      mode_d        = MODE_1;
      mode_change_d = (mode_q != MODE_1);
    end
  end

`ifdef KEY_MODE_LONG_PRESS_EN
  localparam int unsigned       HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(LONG_PRESS_CYCLES);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_press_q;

  // Saturating past the trigger value guarantees a single pulse per hold
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == HELD && state_d == HELD) begin
      hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? hold_cnt_q : hold_cnt_q + HOLD_W'(1);
    end
  end

  assign long_hit = (state_q == HELD) && (hold_cnt_q == HOLD_LAST);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hold_cnt_q   <= '0;
      long_press_q <= 1'b0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      long_press_q <= long_hit;
    end
  end

  assign long_press = long_press_q;
`else
  assign long_hit   = 1'b0;
  assign long_press = 1'b0;
`endif

  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign mode        = mode_q;
  assign mode_change = mode_change_q;

endmodule

`default_nettype wire

// File: tb/tb_key_mode_ctrl.sv
// ============================================================================
// tb_key_mode_ctrl : directed stimulus, run-length reference model, per-cycle compare
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_key_mode_ctrl;

  localparam int DB = 8;
  localparam int LP = 32;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       key_in;
  logic       key_level, key_press, key_release, mode_change, long_press;
  logic [3:0] mode;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_press = 0, n_release = 0, n_mc = 0, n_lp = 0;

  key_mode_ctrl #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .KEY_ACTIVE_LOW    (1)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .mode        (mode),
    .mode_change (mode_change),
    .long_press  (long_press)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the key is a 2-cycle delayed copy of the pin; the level
  // flips once the delayed key has disagreed with it for DB+1 consecutive edges.
  bit         m_valid = 1'b0;
  logic       m_s1, m_s2, m_lvl;
  int         m_run;
  int         m_idx;
  int         m_age;
  logic       e_lvl, e_press, e_rel, e_mc, e_lp;
  logic [3:0] e_mode;

  always @(posedge clk) begin
    logic kk;
    logic held;
    cyc++;
    if (sys_rst) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0;
      m_run = 0; m_idx = 0; m_age = 0;
      e_lvl = 1'b0; e_press = 1'b0; e_rel = 1'b0; e_mc = 1'b0; e_lp = 1'b0;
      e_mode = 4'b0001;
      m_valid = 1'b1;
    end else begin
      kk = m_s2;
      held = m_lvl && (m_run == 0);
      e_press = 1'b0; e_rel = 1'b0; e_mc = 1'b0; e_lp = 1'b0;
`ifdef KEY_MODE_LONG_PRESS_EN
      if (held && m_age == LP - 1) begin
        e_lp = 1'b1;
        e_mc = (m_idx != 0);
        m_idx = 0;
      end
      m_age = (held && kk) ? m_age + 1 : 0;
`else
      m_age = held ? 0 : m_age;
`endif
      m_run = (kk != m_lvl) ? m_run + 1 : 0;
      if (m_run == DB + 1) begin
        m_lvl = kk;
        m_run = 0;
        if (kk) begin
          e_press = 1'b1;
          e_mc = 1'b1;
          m_idx = (m_idx + 1) % 4;
        end else begin
          e_rel = 1'b1;
        end
      end
      e_lvl  = m_lvl;
      e_mode = 4'(1 << m_idx);
      m_s2 = m_s1;
      m_s1 = ~key_in;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cycle_outputs",
          {23'd0, key_level, key_press, key_release, mode, mode_change, long_press},
          {23'd0, e_lvl, e_press, e_rel, e_mode, e_mc, e_lp});
      if (key_press)   n_press++;
      if (key_release) n_release++;
      if (mode_change) n_mc++;
      if (long_press)  n_lp++;
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    wait_n(2);
    sys_rst = 1'b0;
  endtask

  initial begin
    logic [3:0] tbl [4];
    int p0, r0, mc0, lp0;
    tbl[0] = 4'b0010; tbl[1] = 4'b0100; tbl[2] = 4'b1000; tbl[3] = 4'b0001;
    sys_rst = 1'b1;
    key_in  = 1'b1;
    wait_n(3);
    chk("reset_outputs", {23'd0, key_level, key_press, key_release, mode, mode_change, long_press},
        {23'd0, 9'b0_0_0_0001_0_0});
    sys_rst = 1'b0;
    wait_n(4);

    // Test 1: clean press
    key_in = 1'b0;
    wait_n(10);
    chk("t1_press_not_early", {31'd0, key_press}, 32'd0);
    wait_n(1);
    chk("t1_press", {31'd0, key_press}, 32'd1);
    chk("t1_mode_change", {31'd0, mode_change}, 32'd1);
    chk("t1_mode", {28'd0, mode}, 32'h2);
    chk("t1_level", {31'd0, key_level}, 32'd1);
    wait_n(1);
    chk("t1_press_width", {31'd0, key_press}, 32'd0);
    wait_n(4);

    // Test 2: clean release
    key_in = 1'b1;
    wait_n(10);
    chk("t2_release_not_early", {31'd0, key_release}, 32'd0);
    wait_n(1);
    chk("t2_release", {31'd0, key_release}, 32'd1);
    chk("t2_level", {31'd0, key_level}, 32'd0);
    chk("t2_mode", {28'd0, mode}, 32'h2);
    wait_n(4);

    // Test 5: reset in the middle of a press debounce
    key_in = 1'b0;
    wait_n(8);
    sys_rst = 1'b1;
    wait_n(1);
    chk("t5_reset_outputs", {23'd0, key_level, key_press, key_release, mode, mode_change, long_press},
        {23'd0, 9'b0_0_0_0001_0_0});
    wait_n(1);
    sys_rst = 1'b0;
    wait_n(10);
    chk("t5_press_not_early", {31'd0, key_press}, 32'd0);
    wait_n(1);
    chk("t5_press_after_reset", {31'd0, key_press}, 32'd1);
    chk("t5_mode", {28'd0, mode}, 32'h2);
    key_in = 1'b1;
    wait_n(14);

    // Test 3: four press/release pairs from reset
    do_reset();
    mc0 = n_mc;
    for (int i = 0; i < 4; i++) begin
      key_in = 1'b0;
      wait_n(11);
      chk("t3_mode_step", {28'd0, mode}, {28'd0, tbl[i]});
      wait_n(3);
      key_in = 1'b1;
      wait_n(14);
    end
    chk("t3_mode_change_count", n_mc - mc0, 32'd4);

    // Test 4: glitches of 3 and 7 low cycles
    do_reset();
    p0 = n_press; r0 = n_release;
    key_in = 1'b0; wait_n(3);
    key_in = 1'b1; wait_n(2);
    key_in = 1'b0; wait_n(7);
    key_in = 1'b1; wait_n(14);
    chk("t4_no_press", n_press - p0, 32'd0);
    chk("t4_no_release", n_release - r0, 32'd0);
    chk("t4_level", {31'd0, key_level}, 32'd0);
    chk("t4_mode", {28'd0, mode}, 32'h1);

`ifdef KEY_MODE_LONG_PRESS_EN
    // Test 6: long press from mode 0100
    do_reset();
    for (int i = 0; i < 2; i++) begin
      key_in = 1'b0; wait_n(14);
      key_in = 1'b1; wait_n(14);
    end
    chk("t6_start_mode", {28'd0, mode}, 32'h4);
    lp0 = n_lp; mc0 = n_mc;
    key_in = 1'b0;
    wait_n(11);
    chk("t6_press", {31'd0, key_press}, 32'd1);
    chk("t6_press_mode", {28'd0, mode}, 32'h8);
    wait_n(31);
    chk("t6_long_not_early", {31'd0, long_press}, 32'd0);
    wait_n(1);
    chk("t6_long_press", {31'd0, long_press}, 32'd1);
    chk("t6_long_mode", {28'd0, mode}, 32'h1);
    chk("t6_long_mode_change", {31'd0, mode_change}, 32'd1);
    wait_n(7);
    key_in = 1'b1;
    wait_n(11);
    chk("t6_release", {31'd0, key_release}, 32'd1);
    chk("t6_release_mode", {28'd0, mode}, 32'h1);
    chk("t6_long_count", n_lp - lp0, 32'd1);
    chk("t6_mode_change_count", n_mc - mc0, 32'd2);
`else
    lp0 = n_lp;
    key_in = 1'b0; wait_n(60);
    key_in = 1'b1; wait_n(14);
    chk("no_long_press_without_feature", n_lp - lp0, 32'd0);
`endif

    wait_n(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_mode_ctrl.md
Name: key_mode_ctrl

Overview:
Input-side companion to the flow_led pattern engine. It synchronises and debounces the raw board key and produces clean press/release pulses. It also owns the one-hot LED mode register (MODE_1..MODE_4) that flow_led consumes. It sits between the key pin and flow_led's mode input, in the single sys_clk domain.

Parameters:
DEBOUNCE_CYCLES, 2_000_000, stable cycles required before accepting a level change (20 ms at 100 MHz); must be >= 2
LONG_PRESS_CYCLES, 200_000_000, held cycles that qualify as a long press (2 s); used only with the optional feature
KEY_ACTIVE_LOW, 1, 1 = key_in low means pressed; 0 = key_in high means pressed

Ports:
sys_clk       input   1  system clock; all logic on the rising edge
sys_rst       input   1  synchronous, active-high reset
key_in        input   1  raw asynchronous key pin
key_level     output  1  debounced key state, 1 = pressed
key_press     output  1  one-cycle pulse on an accepted press
key_release   output  1  one-cycle pulse on an accepted release
mode          output  4  one-hot LED mode: 0001, 0010, 0100, 1000
mode_change   output  1  one-cycle pulse whenever mode changes
long_press    output  1  one-cycle pulse on a long press (tied 0 without the macro)

Behaviour:
- Interface: one clock, sys_clk; reset sys_rst is synchronous and active-high.
- Reset values: key_level=0, key_press=0, key_release=0, mode=4'b0001, mode_change=0, long_press=0.
  - Reset also sets FSM=IDLE, all counters=0 and both synchroniser flops to the released level.
- Input path:
  - Two-flop synchroniser on key_in.
  - Normalise to pressed=1 per KEY_ACTIVE_LOW; call the result k.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: if k=1, go to PRESS_DB with cnt=0.
  - PRESS_DB: if k=0, return to IDLE and clear cnt. Otherwise cnt++.
    - When cnt==DEBOUNCE_CYCLES-1 with k=1: go to HELD, set key_level=1, pulse key_press.
  - HELD: if k=0, go to RELEASE_DB with cnt=0.
  - RELEASE_DB: mirror of PRESS_DB.
    - k=1 returns to HELD.
    - On completion: go to IDLE, set key_level=0, pulse key_release.
- Latency: with key_in stable from edge N, key_press (or key_release) is high in cycle N+2+DEBOUNCE_CYCLES.
  - Any glitch shorter than DEBOUNCE_CYCLES produces no pulse and no key_level change.
- Mode rotation:
  - On the same edge that asserts key_press, mode rotates left, 1000 wraps to 0001, and mode_change pulses.
  - In the key_press-high cycle, mode already shows the new value.
  - mode is never zero and never multi-hot.
- Pulse timing: pulses are exactly one cycle wide. key_press and key_release are never high in the same cycle.
- Key held through reset release: the stable state is released after reset, so a press is accepted DEBOUNCE_CYCLES+2 cycles after reset deassertion.
- Reset mid-debounce or mid-hold: immediate return to the reset values. No pulse is emitted on the reset edge.
- Counter widths: $clog2 of the largest cycle count in use. Counters saturate and never wrap.

Optional Feature:
Macro: KEY_MODE_LONG_PRESS_EN.
- Defined:
  - A hold counter runs while in HELD and clears on leaving HELD.
  - When it reaches LONG_PRESS_CYCLES-1: pulse long_press once and force mode=0001.
  - mode_change pulses only if mode was not already 0001.
  - The counter then saturates, so there is no repeat during the same hold.
  - The later release follows the normal debounce path and does not rotate mode.
- Not defined:
  - The hold counter is not built and long_press is constant 0.
  - All other behaviour is identical.

Decomposition:
- Package key_mode_pkg holds:
  - the MODE_1..MODE_4 one-hot constants (shared with flow_led);
  - the FSM state typedef (2-bit encoding);
  - a counter-width helper.
- One sub-module, key_sync: the two-flop synchroniser plus polarity normalisation.

Test Plan (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, KEY_ACTIVE_LOW=1):
1. Reset, then drive key_in low at edge N and hold it -> key_press and mode_change high in cycle N+10, mode=0010, key_level=1.
2. Release with key_in high held -> key_release in cycle M+10, key_level=0, mode unchanged.
3. Four clean press/release pairs from reset -> mode steps 0010, 0100, 1000, 0001; exactly 4 mode_change pulses.
4. Low glitches of 3 and 7 cycles separated by 2 high cycles -> no pulses, key_level stays 0, mode=0001.
5. Assert sys_rst at cycle 5 of a PRESS_DB count -> all outputs at reset values on the next cycle. With the key still low, key_press occurs 10 cycles after reset deassertion.
6. With the macro defined, starting from mode=0100, hold the key for 50 cycles -> long_press pulses once 32 cycles after key_press, mode=0001, mode_change pulses. Release produces key_release only.
